commutator: RTL and testbench

Six-step brushless commutation stage feeding the motor driver. Synchronizes the three hall-effect sensor inputs and samples them once per PWM period, on `PWM_synch`. Decodes the rotor position into per-phase drive selects and an 11-bit duty cycle. Also handles regenerative braking, invalid hall codes and motor stall. Outputs change only at PWM period boundaries, so the driver never sees a mid-period select change.

---
 rtl/commutator_if.sv | 27 ++
 rtl/commutator.sv | 130 +++++++++++++
 tb/tb_commutator.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/commutator_if.sv
// Bus bundle between the torque controller / motor driver side and the
// six-step commutator: hall sensors, drive request, PWM boundary strobe,
// and the per-phase selects and duty returned to the driver.
interface commutator_if;
  logic        hallGrn;
  logic        hallYlw;
  logic        hallBlu;
  logic [11:0] drv_mag;
  logic        brake_n;
  logic        PWM_synch;
  logic [1:0]  selGrn;
  logic [1:0]  selYlw;
  logic [1:0]  selBlu;
  logic [10:0] duty;
  logic        stall;
  logic        hall_err;

  modport master (
    output hallGrn, hallYlw, hallBlu, drv_mag, brake_n, PWM_synch,
    input  selGrn, selYlw, selBlu, duty, stall, hall_err
  );

  modport slave (
    input  hallGrn, hallYlw, hallBlu, drv_mag, brake_n, PWM_synch,
    output selGrn, selYlw, selBlu, duty, stall, hall_err
  );
endinterface

// File: rtl/commutator.sv
// Six-step brushless commutator. Hall inputs are double-flopped, then the
// rotor position, brake request and drive magnitude are captured once per
// PWM period. The selects/duty are registered one clock after that capture,
// so the driver only ever sees changes right after a period boundary.
module commutator #(
  parameter int unsigned STALL_PERIODS = 200,
  parameter logic [10:0] BRAKE_DUTY    = 11'h600,
  parameter logic [10:0] DUTY_BASE     = 11'h400
) (
  input logic         clk,
  input logic         rst_n,
  commutator_if.slave bus
);

  localparam logic [7:0] STALL_MAX = 8'(STALL_PERIODS);

  // Hall synchronizer (two flops per sensor), packed as {Grn,Ylw,Blu}.
  logic [2:0]  hall_s1_q, hall_s2_q;

  // Period-sample stage: state captured on PWM_synch.
  logic [2:0]  rot_q;
  logic        brk_q;
  logic [11:0] mag_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        vld_p1_q;

  // Output stage.
  logic [1:0]  selGrn_q, selYlw_q, selBlu_q;
  logic [10:0] duty_q;
  logic        stall_q, hall_err_q;

  logic [5:0]  sel_d;
  logic [10:0] duty_d;
  logic        stall_d, hall_err_d;

  // Commutation table: rotor code -> {Grn,Ylw,Blu} selects; invalid codes coast.
  function automatic logic [5:0] decode(input logic [2:0] code);
    case (code)
      3'b101:  decode = {2'b10, 2'b01, 2'b00};
      3'b100:  decode = {2'b10, 2'b00, 2'b01};
      3'b110:  decode = {2'b00, 2'b10, 2'b01};
      3'b010:  decode = {2'b01, 2'b10, 2'b00};
      3'b011:  decode = {2'b01, 2'b00, 2'b10};
      3'b001:  decode = {2'b00, 2'b01, 2'b10};
      default: decode = 6'b00_00_00;
    endcase
  endfunction

  // Metastability synchronizer for the raw hall sensors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hall_s1_q <= 3'b000;
      hall_s2_q <= 3'b000;
    end else begin
      hall_s1_q <= {bus.hallGrn, bus.hallYlw, bus.hallBlu};
      hall_s2_q <= hall_s1_q;
    end
  end

  // Stall counter next value: any rotor movement, brake or zero drive restarts it.
  always_comb begin
    cnt_d = cnt_q;
    if ((hall_s2_q != rot_q) || !bus.brake_n || (bus.drv_mag == 12'h000)) begin
      cnt_d = 8'h00;
    end else if (cnt_q != STALL_MAX) begin
      cnt_d = cnt_q + 8'h01;
    end
  end

  // ---- stage p0 -> p1: capture position, brake, magnitude at the period boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_q    <= 3'b000;
      brk_q    <= 1'b0;
      mag_q    <= 12'h000;
      cnt_q    <= 8'h00;
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= bus.PWM_synch;
      if (bus.PWM_synch) begin
        rot_q <= hall_s2_q;
        brk_q <= ~bus.brake_n;
        mag_q <= bus.drv_mag;
        cnt_q <= cnt_d;
      end
    end
  end

  // Select/duty priority: brake, then stall, then invalid hall, then normal drive.
  always_comb begin
    hall_err_d = (rot_q == 3'b000) || (rot_q == 3'b111);
    stall_d    = (cnt_q == STALL_MAX);
    sel_d      = 6'b00_00_00;
    duty_d     = 11'h000;
    if (brk_q) begin
      sel_d  = 6'b11_11_11;
      duty_d = BRAKE_DUTY;
    end else if (!stall_d && !hall_err_d) begin
      sel_d  = decode(rot_q);
      duty_d = DUTY_BASE + {1'b0, mag_q[11:2]};
    end
  end

  // ---- stage p1 -> out: register all outputs together, one clock after the sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      selGrn_q   <= 2'b00;
      selYlw_q   <= 2'b00;
      selBlu_q   <= 2'b00;
      duty_q     <= 11'h000;
      stall_q    <= 1'b0;
      hall_err_q <= 1'b0;
    end else if (vld_p1_q) begin
      selGrn_q   <= sel_d[5:4];
      selYlw_q   <= sel_d[3:2];
      selBlu_q   <= sel_d[1:0];
      duty_q     <= duty_d;
      stall_q    <= stall_d;
      hall_err_q <= hall_err_d;
    end
  end

  assign bus.selGrn   = selGrn_q;
  assign bus.selYlw   = selYlw_q;
  assign bus.selBlu   = selBlu_q;
  assign bus.duty     = duty_q;
  assign bus.stall    = stall_q;
  assign bus.hall_err = hall_err_q;

endmodule

// File: tb/tb_commutator.sv
// Bench for the six-step commutator: a period-level reference model checked
// every cycle, plus directed scenarios with literal expected output words
// packed as {selGrn, selYlw, selBlu, duty, stall, hall_err}.
module tb_commutator;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  commutator_if bus();

  commutator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state.
  logic [2:0]  m_h1, m_h2, m_rot;
  logic        m_brk, m_pend;
  logic [11:0] m_mag;
  int          m_cnt;
  logic [18:0] m_exp;

  function automatic logic [5:0] sel_table(input logic [2:0] c);
    logic [5:0] r;
    r = 6'b000000;
    if (c == 3'b101) r = 6'b10_01_00;
    if (c == 3'b100) r = 6'b10_00_01;
    if (c == 3'b110) r = 6'b00_10_01;
    if (c == 3'b010) r = 6'b01_10_00;
    if (c == 3'b011) r = 6'b01_00_10;
    if (c == 3'b001) r = 6'b00_01_10;
    return r;
  endfunction

  function automatic logic [18:0] dut_word();
    return {bus.selGrn, bus.selYlw, bus.selBlu, bus.duty, bus.stall, bus.hall_err};
  endfunction

  // Model: two-clock hall delay, period sampling, priority rules, output one clock later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_h1 = 3'b000; m_h2 = 3'b000; m_rot = 3'b000;
      m_brk = 1'b0; m_mag = 12'h000; m_cnt = 0; m_pend = 1'b0;
      m_exp = '0;
    end else begin
      if (m_pend) begin
        logic err, stl;
        err = (m_rot == 3'b000) || (m_rot == 3'b111);
        stl = (m_cnt == 200);
        if (m_brk)     m_exp = {6'b111111, 11'h600, stl, err};
        else if (stl)  m_exp = {6'b000000, 11'h000, 1'b1, err};
        else if (err)  m_exp = {6'b000000, 11'h000, 1'b0, 1'b1};
        else           m_exp = {sel_table(m_rot), 11'(11'h400 + int'(m_mag / 4)), 1'b0, 1'b0};
      end
      m_pend = bus.PWM_synch;
      if (bus.PWM_synch) begin
        if (m_h2 != m_rot || !bus.brake_n || bus.drv_mag == 12'h000) m_cnt = 0;
        else if (m_cnt < 200) m_cnt = m_cnt + 1;
        m_rot = m_h2;
        m_brk = !bus.brake_n;
        m_mag = bus.drv_mag;
      end
      m_h2 = m_h1;
      m_h1 = {bus.hallGrn, bus.hallYlw, bus.hallBlu};
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    n_cmp++;
    if (dut_word() !== m_exp) begin
      n_bad++;
      $display("FAIL model_cycle t=%0t got=%h expected=%h", $time, dut_word(), m_exp);
    end
  end

  task automatic check(input string name, input logic [18:0] exp);
    n_cmp++;
    if (dut_word() !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", name, dut_word(), exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_in(input logic [2:0] h, input logic [11:0] m, input logic bn);
    bus.hallGrn = h[2];
    bus.hallYlw = h[1];
    bus.hallBlu = h[0];
    bus.drv_mag = m;
    bus.brake_n = bn;
    tick(3);
  endtask

  task automatic pulse();
    bus.PWM_synch = 1'b1;
    tick(1);
    bus.PWM_synch = 1'b0;
    tick(1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog t=%0t got=running expected=finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.hallGrn = 1'b0; bus.hallYlw = 1'b0; bus.hallBlu = 1'b0;
    bus.drv_mag = 12'h000; bus.brake_n = 1'b1; bus.PWM_synch = 1'b0;
    #23;
    check("reset_state", 19'h0);
    rst_n = 1'b1;
    tick(2);

    // Six-step sequence at drv_mag 0x800 -> duty 0x600.
    set_in(3'b101, 12'h800, 1'b1); pulse(); check("step_101", {6'b10_01_00, 11'h600, 2'b00});
    set_in(3'b100, 12'h800, 1'b1); pulse(); check("step_100", {6'b10_00_01, 11'h600, 2'b00});
    set_in(3'b110, 12'h800, 1'b1); pulse(); check("step_110", {6'b00_10_01, 11'h600, 2'b00});
    set_in(3'b010, 12'h800, 1'b1); pulse(); check("step_010", {6'b01_10_00, 11'h600, 2'b00});
    set_in(3'b011, 12'h800, 1'b1); pulse(); check("step_011", {6'b01_00_10, 11'h600, 2'b00});
    set_in(3'b001, 12'h800, 1'b1); pulse(); check("step_001", {6'b00_01_10, 11'h600, 2'b00});

    // Brake overrides, then releases back to table drive.
    set_in(3'b110, 12'h800, 1'b0); pulse(); check("brake_on", {6'b11_11_11, 11'h600, 2'b00});
    set_in(3'b110, 12'h800, 1'b1); pulse(); check("brake_off", {6'b00_10_01, 11'h600, 2'b00});

    // Invalid hall code, then recovery.
    set_in(3'b111, 12'h800, 1'b1); pulse(); check("hall_111", {6'b000000, 11'h000, 2'b01});
    set_in(3'b001, 12'h800, 1'b1); pulse(); check("hall_001", {6'b00_01_10, 11'h600, 2'b00});

    // Inputs changed between boundaries are ignored until the next boundary.
    set_in(3'b100, 12'h800, 1'b1); pulse(); check("mid_before", {6'b10_00_01, 11'h600, 2'b00});
    set_in(3'b110, 12'hC00, 1'b1); tick(3);
    check("mid_hold", {6'b10_00_01, 11'h600, 2'b00});
    pulse(); check("mid_update", {6'b00_10_01, 11'h700, 2'b00});

    // Stall: frozen at 100, full drive; stall on the 200th unchanged sample.
    set_in(3'b100, 12'hFFF, 1'b1); pulse();
    repeat (199) pulse();
    check("stall_199", {6'b10_00_01, 11'h7FF, 2'b00});
    pulse(); check("stall_200", {6'b000000, 11'h000, 2'b10});
    pulse(); check("stall_hold", {6'b000000, 11'h000, 2'b10});
    set_in(3'b110, 12'hFFF, 1'b1); pulse(); check("stall_exit", {6'b00_10_01, 11'h7FF, 2'b00});

    // PWM_synch held high for several cycles: every cycle is a sample.
    set_in(3'b010, 12'h400, 1'b1);
    bus.PWM_synch = 1'b1; tick(3); bus.PWM_synch = 1'b0; tick(1);
    check("synch_held", {6'b01_10_00, 11'h500, 2'b00});

    // Asynchronous reset mid-drive, then hold at zero until the first boundary.
    #1 rst_n = 1'b0;
    #1 check("async_reset", 19'h0);
    #3 rst_n = 1'b1;
    tick(4);
    check("post_reset_hold", 19'h0);
    pulse(); check("post_reset_drive", {6'b01_10_00, 11'h500, 2'b00});

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
